cfar_power_streamer: RTL and testbench
======================================

# cfar_power_streamer

Source side of the CFAR detector stream. Accepts complex samples on a ready/valid input, converts each to power (re² + im²), buffers exactly one frame of POINT_LENGTH points, then replays the frame to the detector interface forward or reversed, with index, valid and end-of-packet. After replay it waits for the detector's max_valid before accepting the next frame, so detector results are never overlapped.

## Interface
Parameters:
- POINT_LENGTH, 512, points per frame
- SAMPLE_WIDTH, 14, signed width of re/im
- INPUT_WIDTH, 29, power width; must be ≥ 2*SAMPLE_WIDTH+1
- INDEX_WIDTH, 9, index width; POINT_LENGTH ≤ 2**INDEX_WIDTH

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  streamer can accept a sample
- s_re  in  SAMPLE_WIDTH  signed real part
- s_im  in  SAMPLE_WIDTH  signed imaginary part
- s_last  in  1  sender marks last sample of frame
- dir_in  in  1  replay direction request; 0 = increasing index, 1 = decreasing
- power_in  out  INPUT_WIDTH  power sample to detector
- index_in  out  INDEX_WIDTH  index of power_in
- reverse  out  1  direction of the current replay
- input_valid  out  1  power_in/index_in valid
- eop_in  out  1  last point of replay, coincident with input_valid
- max_valid  in  1  detector result pulse, ends the frame
- frame_err  out  1  one-cycle pulse on s_last misalignment
- frame_cnt  out  16  completed frames, wraps at 2**16

## Operation
- States: FILL, FLUSH, PLAY, WAIT_DONE. Reset → FILL.
- FILL: s_ready=1. Accept on s_valid&&s_ready. Power = re*re + im*im, unsigned, zero-extended to INPUT_WIDTH (max 2^(2*SAMPLE_WIDTH-1)). Registered, written to RAM at wr_ptr one cycle after accept; wr_ptr increments 0..POINT_LENGTH-1. The accept with wr_ptr==POINT_LENGTH-1 → FLUSH. On that same edge, latch reverse ← dir_in.
- Frame length is fixed. s_last never shortens or extends a frame. frame_err pulses the cycle after an accept where s_last ≠ (wr_ptr==POINT_LENGTH-1).
- FLUSH: one cycle, s_ready=0. The last RAM write completes. → PLAY.
- PLAY: issue read addresses, one per cycle, with no gaps: 0..N-1 if reverse=0, N-1..0 if reverse=1. After the last address → WAIT_DONE. The detector has no backpressure.
- WAIT_DONE: s_ready=0. max_valid=1 → frame_cnt+1, reverse kept, → FILL. max_valid is ignored in every other state.
- reverse holds its latched value from FLUSH through WAIT_DONE.

## Timing
- Last sample accepted at edge T. FLUSH during cycle T+1. First read address in cycle T+2. RAM read latency is 1, so input_valid is high from T+3 to T+2+N inclusive, and eop_in is high only in cycle T+2+N.
- index_in equals the RAM address of the power_in presented with it. First index is 0 (forward) or N-1 (reverse).
- s_ready returns to 1 in the cycle after max_valid is sampled in WAIT_DONE.
- Reset values: s_ready=0 while reset is high, and 1 from the first cycle after release. power_in, index_in, reverse, input_valid, eop_in, frame_err are 0; frame_cnt=0.
- Reset mid-frame: state, pointers, pipeline and outputs clear on the next edge. A partial frame is discarded. RAM contents are not cleared and need not be.
- input_valid/eop_in never assert outside PLAY+1 cycle.

## Structure
- Shared package cfar_pkg: state enum (FILL, FLUSH, PLAY, WAIT_DONE) and a function computing power width from SAMPLE_WIDTH. Defaults stay consistent with the detector interface (512/29/9).
- Sub-module cfar_power_ram: simple dual-port, one write port, one synchronous read port, POINT_LENGTH × INPUT_WIDTH, 1-cycle read latency, no reset.
- Top holds the FSM, the squaring/add register, the pointers, frame_err and frame_cnt.

## Test plan
- POINT_LENGTH=8, INDEX_WIDTH=3, dir_in=0, samples re=k, im=1 for k=0..7 with s_last on k=7 → input_valid for 8 consecutive cycles, power_in 1,2,5,10,17,26,37,50, index_in 0..7, eop_in with index 7, frame_err never.
- Same frame with dir_in=1 → index_in 7..0, power_in 50..1, reverse=1 throughout, eop_in with index 0.
- Extremes re=im=-8192 (SAMPLE_WIDTH=14) → power_in=134217728, no truncation.
- s_last on sample 3 and absent on sample 7 → frame_err pulses twice, the frame is still 8 points, and replay is normal.
- Send the next frame while in PLAY/WAIT_DONE, then hold max_valid low for 20 cycles → s_ready stays 0. max_valid pulse → frame_cnt=1, s_ready=1 next cycle.
- Assert reset during PLAY at index 4 → input_valid=0 the next cycle. A following full frame replays correctly starting from index 0.

Source files
------------

// File: rtl/cfar_pkg.sv
// Shared definitions for the CFAR detector source path: streamer states,
// default geometry and the power-width helper.
package cfar_pkg;

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        PLAY,
        WAIT_DONE
    } cfar_state_t;

    localparam int DEFAULT_POINT_LENGTH = 512;
    localparam int DEFAULT_SAMPLE_WIDTH = 14;
    localparam int DEFAULT_INDEX_WIDTH  = 9;

    // re^2 + im^2 of two signed values needs one bit more than a single product
    function automatic int power_width(input int sample_width);
        return 2 * sample_width + 1;
    endfunction

endpackage

// File: rtl/cfar_power_ram.sv
// One-frame power buffer: one write port, one synchronous read port,
// single-cycle read latency, no reset on the storage or read register.
module cfar_power_ram #(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 29,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cfar_power_streamer.sv
// Converts complex samples to power, buffers one frame and replays it to the
// CFAR detector forward or reversed, then waits for max_valid before refilling.
module cfar_power_streamer
    import cfar_pkg::*;
#(
    parameter int POINT_LENGTH = DEFAULT_POINT_LENGTH,
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int INPUT_WIDTH  = power_width(DEFAULT_SAMPLE_WIDTH),
    parameter int INDEX_WIDTH  = DEFAULT_INDEX_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] s_re,
    input  logic signed [SAMPLE_WIDTH-1:0] s_im,
    input  logic                           s_last,
    input  logic                           dir_in,
    output logic [INPUT_WIDTH-1:0]         power_in,
    output logic [INDEX_WIDTH-1:0]         index_in,
    output logic                           reverse,
    output logic                           input_valid,
    output logic                           eop_in,
    input  logic                           max_valid,
    output logic                           frame_err,
    output logic [15:0]                    frame_cnt
);

    localparam int PW = 2 * SAMPLE_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(POINT_LENGTH - 1);

    cfar_state_t state, state_next;

    logic [INDEX_WIDTH-1:0] wr_ptr, rd_ptr, wr_addr;
    logic [INPUT_WIDTH-1:0] wr_data, rd_data, power_next;
    logic                   wr_en;
    logic                   accept, wr_last, rd_last, play;

    logic signed [PW-1:0] re_ext, im_ext;
    logic        [PW-1:0] re_sq, im_sq;
    logic        [PW:0]   power_sum;

    // Sign-extend before squaring so each square is exact; the sum is unsigned
    // so the 2^(2*SAMPLE_WIDTH-1) extreme does not wrap.
    assign re_ext     = PW'(s_re);
    assign im_ext     = PW'(s_im);
    assign re_sq      = re_ext * re_ext;
    assign im_sq      = im_ext * im_ext;
    assign power_sum  = {1'b0, re_sq} + {1'b0, im_sq};
    assign power_next = INPUT_WIDTH'(power_sum);

    assign s_ready = (state == FILL) && !reset;
    assign accept  = s_valid && s_ready;
    assign wr_last = (wr_ptr == LAST_IDX);
    assign play    = (state == PLAY);
    assign rd_last = reverse ? (rd_ptr == '0) : (rd_ptr == LAST_IDX);

    // The RAM read register has no reset, so power is gated by valid.
    assign power_in = input_valid ? rd_data : '0;

    always_comb begin
        state_next = state;
        case (state)
            FILL:      if (accept && wr_last) state_next = FLUSH;
            FLUSH:     state_next = PLAY;
            PLAY:      if (rd_last) state_next = WAIT_DONE;
            WAIT_DONE: if (max_valid) state_next = FILL;
            default:   state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            wr_ptr    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            reverse   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            wr_en     <= accept;
            frame_err <= accept && (s_last != wr_last);
            if (accept) begin
                wr_addr <= wr_ptr;
                wr_data <= power_next;
                wr_ptr  <= wr_last ? '0 : wr_ptr + 1'b1;
                if (wr_last) begin
                    reverse <= dir_in;
                end
            end
            if ((state == WAIT_DONE) && max_valid) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Index and flags are delayed one cycle to line up with the RAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            index_in    <= '0;
            input_valid <= 1'b0;
            eop_in      <= 1'b0;
        end else begin
            input_valid <= play;
            eop_in      <= play && rd_last;
            index_in    <= play ? rd_ptr : '0;
            if (state == FLUSH) begin
                rd_ptr <= reverse ? LAST_IDX : '0;
            end else if (play && !rd_last) begin
                rd_ptr <= reverse ? rd_ptr - 1'b1 : rd_ptr + 1'b1;
            end
        end
    end

    cfar_power_ram #(
        .DEPTH      (POINT_LENGTH),
        .DATA_WIDTH (INPUT_WIDTH),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_cfar_power_streamer.sv
// Directed bench for cfar_power_streamer with 8-point frames: table-driven
// frames plus hand-written backpressure, ignored max_valid and mid-replay reset.
module tb_cfar_power_streamer;

    localparam int N  = 8;
    localparam int SW = 14;
    localparam int IW = 29;
    localparam int XW = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [SW-1:0] s_re = '0;
    logic signed [SW-1:0] s_im = '0;
    logic                 s_last = 1'b0;
    logic                 dir_in = 1'b0;
    logic [IW-1:0]        power_in;
    logic [XW-1:0]        index_in;
    logic                 reverse;
    logic                 input_valid;
    logic                 eop_in;
    logic                 max_valid = 1'b0;
    logic                 frame_err;
    logic [15:0]          frame_cnt;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
        logic                 last;
        logic [IW-1:0]        power;
    } vec_t;

    vec_t vecs [3][N];

    cfar_power_streamer #(
        .POINT_LENGTH (N),
        .SAMPLE_WIDTH (SW),
        .INPUT_WIDTH  (IW),
        .INDEX_WIDTH  (XW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_re        (s_re),
        .s_im        (s_im),
        .s_last      (s_last),
        .dir_in      (dir_in),
        .power_in    (power_in),
        .index_in    (index_in),
        .reverse     (reverse),
        .input_valid (input_valid),
        .eop_in      (eop_in),
        .max_valid   (max_valid),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Sends one frame from table f; dir_in carries the wanted direction only on the final accept.
    task automatic applyStimulus(input int f, input logic dir);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i > 0) checkOutput("frame_err", 32'(frame_err), 32'(vecs[f][i-1].last != (i-1 == N-1)));
            checkOutput("s_ready_fill", 32'(s_ready), 32'd1);
            s_valid = 1'b1;
            s_re    = vecs[f][i].re;
            s_im    = vecs[f][i].im;
            s_last  = vecs[f][i].last;
            dir_in  = (i == N-1) ? dir : ~dir;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        dir_in  = ~dir;
        checkOutput("frame_err", 32'(frame_err), 32'(vecs[f][N-1].last != 1'b1));
        checkOutput("s_ready_flush", 32'(s_ready), 32'd0);
    endtask

    // Called at the FLUSH negedge; checks the replay window cycle by cycle.
    task automatic checkReplay(input int f, input logic dir, input bit noise, input int abort_at);
        int idx;
        @(negedge clk);
        checkOutput("valid_before_data", 32'(input_valid), 32'd0);
        if (noise) begin
            s_valid   = 1'b1;
            max_valid = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (noise && k == N-1) max_valid = 1'b0;
            idx = dir ? N-1-k : k;
            checkOutput("input_valid", 32'(input_valid), 32'd1);
            checkOutput("index_in", 32'(index_in), 32'(idx));
            checkOutput("power_in", 32'(power_in), 32'(vecs[f][idx].power));
            checkOutput("eop_in", 32'(eop_in), 32'(k == N-1));
            checkOutput("reverse", 32'(reverse), 32'(dir));
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                checkOutput("valid_after_reset", 32'(input_valid), 32'd0);
                checkOutput("eop_after_reset", 32'(eop_in), 32'd0);
                checkOutput("index_after_reset", 32'(index_in), 32'd0);
                checkOutput("s_ready_in_reset", 32'(s_ready), 32'd0);
                checkOutput("frame_cnt_reset", 32'(frame_cnt), 32'd0);
                reset     = 1'b0;
                s_valid   = 1'b0;
                max_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        checkOutput("valid_after_eop", 32'(input_valid), 32'd0);
        checkOutput("eop_after_eop", 32'(eop_in), 32'd0);
        checkOutput("reverse_wait", 32'(reverse), 32'(dir));
        checkOutput("s_ready_wait", 32'(s_ready), 32'd0);
    endtask

    task automatic finishFrame(input int exp_cnt, input logic dir);
        @(negedge clk);
        checkOutput("s_ready_wait", 32'(s_ready), 32'd0);
        checkOutput("frame_cnt_before", 32'(frame_cnt), 32'(exp_cnt - 1));
        max_valid = 1'b1;
        @(negedge clk);
        max_valid = 1'b0;
        checkOutput("s_ready_refill", 32'(s_ready), 32'd1);
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        checkOutput("reverse_kept", 32'(reverse), 32'(dir));
        s_valid = 1'b0;
    endtask

    initial begin
        // Frame 0: re=k, im=1, s_last on the final sample
        for (int i = 0; i < N; i++) begin
            vecs[0][i].re    = SW'(i);
            vecs[0][i].im    = 14'sd1;
            vecs[0][i].last  = (i == N-1);
            vecs[0][i].power = IW'(i * i + 1);
        end
        // Frame 1: extremes and mixed signs
        vecs[1][0] = '{re: -14'sd8192, im: -14'sd8192, last: 1'b0, power: 29'd134217728};
        vecs[1][1] = '{re:  14'sd8191, im:  14'sd8191, last: 1'b0, power: 29'd134184962};
        vecs[1][2] = '{re: -14'sd8192, im:  14'sd0,    last: 1'b0, power: 29'd67108864};
        vecs[1][3] = '{re:  14'sd0,    im:  14'sd0,    last: 1'b0, power: 29'd0};
        vecs[1][4] = '{re: -14'sd1,    im: -14'sd1,    last: 1'b0, power: 29'd2};
        vecs[1][5] = '{re:  14'sd100,  im: -14'sd200,  last: 1'b0, power: 29'd50000};
        vecs[1][6] = '{re: -14'sd8192, im:  14'sd8191, last: 1'b0, power: 29'd134201345};
        vecs[1][7] = '{re:  14'sd3,    im:  14'sd4,    last: 1'b1, power: 29'd25};
        // Frame 2: same data as frame 0 but s_last misplaced on sample 3
        for (int i = 0; i < N; i++) begin
            vecs[2][i]      = vecs[0][i];
            vecs[2][i].last = (i == 3);
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_power_in", 32'(power_in), 32'd0);
        checkOutput("rst_index_in", 32'(index_in), 32'd0);
        checkOutput("rst_reverse", 32'(reverse), 32'd0);
        checkOutput("rst_input_valid", 32'(input_valid), 32'd0);
        checkOutput("rst_eop_in", 32'(eop_in), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s_ready_after_reset", 32'(s_ready), 32'd1);

        $display("[TB] forward frame");
        applyStimulus(0, 1'b0);
        checkReplay(0, 1'b0, 1'b0, -1);
        finishFrame(1, 1'b0);

        $display("[TB] reversed frame");
        applyStimulus(0, 1'b1);
        checkReplay(0, 1'b1, 1'b0, -1);
        finishFrame(2, 1'b1);

        $display("[TB] extreme powers");
        applyStimulus(1, 1'b0);
        checkReplay(1, 1'b0, 1'b0, -1);
        finishFrame(3, 1'b0);

        $display("[TB] misplaced s_last");
        applyStimulus(2, 1'b1);
        checkReplay(2, 1'b1, 1'b0, -1);
        finishFrame(4, 1'b1);

        // Next frame offered during replay and wait; max_valid during PLAY must be ignored
        $display("[TB] held off next frame");
        applyStimulus(0, 1'b0);
        checkReplay(0, 1'b0, 1'b1, -1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("s_ready_held", 32'(s_ready), 32'd0);
            checkOutput("valid_held", 32'(input_valid), 32'd0);
        end
        checkOutput("frame_cnt_held", 32'(frame_cnt), 32'd4);
        finishFrame(5, 1'b0);

        $display("[TB] reset during replay");
        applyStimulus(1, 1'b1);
        checkReplay(1, 1'b1, 1'b0, 4);
        @(negedge clk);
        checkOutput("s_ready_post_reset", 32'(s_ready), 32'd1);
        applyStimulus(0, 1'b0);
        checkReplay(0, 1'b0, 1'b0, -1);
        finishFrame(1, 1'b0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
